// File: rtl/anc_adapt_sched.sv
// Tap-sweep sequencer for the shared LMS weight-update datapath: one read,
// DP_LAT datapath cycles and one weight write-back per tap, once per audio sample.
module anc_adapt_sched #(
  parameter int NTAPS  = 16,
  parameter int AW     = 4,
  parameter int DP_LAT = 2
) (
  input  logic          Clk_100M,
  input  logic          Reset,
  input  logic          Start,
  input  logic [10:0]   Err_In,
  output logic [AW-1:0] Tap_Addr,
  output logic          Rd_En,
  input  logic [10:0]   Sig_Data,
  input  logic [10:0]   Wz_Data,
  output logic          Adapt_En,
  output logic [10:0]   Adapt_Sig,
  output logic [10:0]   Adapt_Err,
  output logic [10:0]   Adapt_Wz,
  input  logic [10:0]   Adapt_WzOut,
  output logic          Wz_Wr_En,
  output logic [AW-1:0] Wz_Wr_Addr,
  output logic [10:0]   Wz_Wr_Data,
  output logic          Busy,
  output logic          Done,
  output logic          Overrun
);

  localparam int LW = (DP_LAT > 1) ? $clog2(DP_LAT) : 1;
  localparam logic [AW-1:0] LAST_TAP = AW'(NTAPS - 1);
  localparam logic [LW-1:0] LAST_LAT = LW'(DP_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_EXEC  = 3'd2,
    S_WRITE = 3'd3,
    S_FIN   = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] tap_q, tap_d;
  logic [LW-1:0] lat_q, lat_d;
  logic [10:0]   err_q, err_d;
  logic [10:0]   sig_q, sig_d;
  logic [10:0]   wz_q, wz_d;
  logic [10:0]   wr_data_q, wr_data_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic          rd_en_q, rd_en_d;
  logic          en_q, en_d;
  logic          wr_en_q, wr_en_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          overrun_q, overrun_d;

  // Next-state, datapath operand capture and output decode from the next state
  always_comb begin
    state_d   = state_q;
    tap_d     = tap_q;
    lat_d     = lat_q;
    err_d     = err_q;
    sig_d     = sig_q;
    wz_d      = wz_q;
    wr_data_d = wr_data_q;
    overrun_d = Start && (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          err_d = Err_In;
          tap_d = {AW{1'b0}};
          // A zero-magnitude error cannot move any weight, so skip the sweep
          state_d = (Err_In[9:0] == 10'd0) ? S_FIN : S_READ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        lat_d   = {LW{1'b0}};
        state_d = S_EXEC;
      end
      S_EXEC: begin
        // Memory data arrives during the first EXEC cycle (one-cycle read latency)
        if (lat_q == {LW{1'b0}}) begin
          sig_d = Sig_Data;
          wz_d  = Wz_Data;
        end else begin
          sig_d = sig_q;
        end
        if (lat_q == LAST_LAT) begin
          wr_data_d = Adapt_WzOut;
          state_d   = S_WRITE;
        end else begin
          lat_d = lat_q + {{(LW-1){1'b0}}, 1'b1};
        end
      end
      S_WRITE: begin
        if (tap_q == LAST_TAP) begin
          tap_d   = {AW{1'b0}};
          state_d = S_FIN;
        end else begin
          tap_d   = tap_q + {{(AW-1){1'b0}}, 1'b1};
          state_d = S_READ;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        tap_d   = {AW{1'b0}};
        state_d = S_IDLE;
      end
    endcase

    rd_en_d   = (state_d == S_READ);
    en_d      = (state_d == S_EXEC);
    wr_en_d   = (state_d == S_WRITE);
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_FIN);
    wr_addr_d = (state_d == S_WRITE) ? tap_q : wr_addr_q;
  end

  // State and registered outputs; reset clears everything and drops any pending write
  always_ff @(posedge Clk_100M) begin
    if (!Reset) begin
      state_q   <= S_IDLE;
      tap_q     <= {AW{1'b0}};
      lat_q     <= {LW{1'b0}};
      err_q     <= 11'd0;
      sig_q     <= 11'd0;
      wz_q      <= 11'd0;
      wr_data_q <= 11'd0;
      wr_addr_q <= {AW{1'b0}};
      rd_en_q   <= 1'b0;
      en_q      <= 1'b0;
      wr_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tap_q     <= tap_d;
      lat_q     <= lat_d;
      err_q     <= err_d;
      sig_q     <= sig_d;
      wz_q      <= wz_d;
      wr_data_q <= wr_data_d;
      wr_addr_q <= wr_addr_d;
      rd_en_q   <= rd_en_d;
      en_q      <= en_d;
      wr_en_q   <= wr_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  assign Tap_Addr   = tap_q;
  assign Rd_En      = rd_en_q;
  assign Adapt_En   = en_q;
  assign Adapt_Sig  = sig_q;
  assign Adapt_Err  = err_q;
  assign Adapt_Wz   = wz_q;
  assign Wz_Wr_En   = wr_en_q;
  assign Wz_Wr_Addr = wr_addr_q;
  assign Wz_Wr_Data = wr_data_q;
  assign Busy       = busy_q;
  assign Done       = done_q;
  assign Overrun    = overrun_q;

endmodule

// File: tb/tb_anc_adapt_sched.sv
// Directed bench for anc_adapt_sched with NTAPS=4, DP_LAT=2, AW=3, a one-cycle
// memory model and a datapath model that returns old weight + 1.
module tb_anc_adapt_sched;

  localparam int NTAPS  = 4;
  localparam int AW     = 3;
  localparam int DP_LAT = 2;
  localparam int SWEEP  = NTAPS * (DP_LAT + 2) + 1;

  logic          clk = 1'b0;
  logic          Reset = 1'b0;
  logic          Start = 1'b0;
  logic [10:0]   Err_In = 11'd0;
  logic [AW-1:0] Tap_Addr;
  logic          Rd_En;
  logic [10:0]   Sig_Data = 11'd0;
  logic [10:0]   Wz_Data = 11'd0;
  logic          Adapt_En;
  logic [10:0]   Adapt_Sig, Adapt_Err, Adapt_Wz, Adapt_WzOut;
  logic          Wz_Wr_En;
  logic [AW-1:0] Wz_Wr_Addr;
  logic [10:0]   Wz_Wr_Data;
  logic          Busy, Done, Overrun;

  int checks = 0;
  int failures = 0;

  logic [10:0] sig_mem [4] = '{11'h101, 11'h102, 11'h103, 11'h404};
  logic [10:0] wz_mem  [4] = '{11'h010, 11'h020, 11'h030, 11'h040};
  logic [10:0] exp_w   [4];

  logic [2:0]  wr_addr_qu[$];
  logic [10:0] wr_data_qu[$];
  logic [10:0] wr_sig_qu[$];
  int rd_cnt = 0, overlap_cnt = 0, range_cnt = 0, run_len = 0, runs = 0, bad_run = 0;

  always #5 clk = ~clk;

  anc_adapt_sched #(.NTAPS(NTAPS), .AW(AW), .DP_LAT(DP_LAT)) dut (
    .Clk_100M(clk), .Reset(Reset), .Start(Start), .Err_In(Err_In),
    .Tap_Addr(Tap_Addr), .Rd_En(Rd_En), .Sig_Data(Sig_Data), .Wz_Data(Wz_Data),
    .Adapt_En(Adapt_En), .Adapt_Sig(Adapt_Sig), .Adapt_Err(Adapt_Err), .Adapt_Wz(Adapt_Wz),
    .Adapt_WzOut(Adapt_WzOut), .Wz_Wr_En(Wz_Wr_En), .Wz_Wr_Addr(Wz_Wr_Addr),
    .Wz_Wr_Data(Wz_Wr_Data), .Busy(Busy), .Done(Done), .Overrun(Overrun)
  );

  assign Adapt_WzOut = Adapt_Wz + 11'd1;

  // Memories: registered read data, write-back of updated weights
  always @(posedge clk) begin
    if (Rd_En) begin
      Sig_Data <= sig_mem[Tap_Addr[1:0]];
      Wz_Data  <= wz_mem[Tap_Addr[1:0]];
    end
    if (Wz_Wr_En) wz_mem[Wz_Wr_Addr[1:0]] <= Wz_Wr_Data;
  end

  // Bus observer: logs writes and protocol events for the scenario tasks
  always @(negedge clk) begin
    if (Wz_Wr_En) begin
      wr_addr_qu.push_back(Wz_Wr_Addr);
      wr_data_qu.push_back(Wz_Wr_Data);
      wr_sig_qu.push_back(Adapt_Sig);
    end
    if (Rd_En) rd_cnt++;
    if ((Rd_En && Wz_Wr_En) || (Adapt_En && (Rd_En || Wz_Wr_En))) overlap_cnt++;
    if (Tap_Addr > 3'd3) range_cnt++;
    if (Adapt_En) run_len++;
    else if (run_len != 0) begin
      if (run_len != DP_LAT) bad_run++;
      runs++;
      run_len = 0;
    end
  end

  task automatic run_sweep(input logic [10:0] err, output int done_cyc, output int busy_cyc);
    int cyc;
    Start = 1'b1; Err_In = err;
    @(negedge clk);
    Start = 1'b0;
    done_cyc = 0; busy_cyc = 0; cyc = 1;
    while (cyc < 200) begin
      if (Busy) busy_cyc++;
      if (Done) begin done_cyc = cyc; break; end
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    Reset = 1'b0; Start = 1'b1; Err_In = 11'h7FF;
    repeat (2) @(negedge clk);
    checks++;
    if ({Tap_Addr, Rd_En, Adapt_En, Adapt_Sig, Adapt_Err, Adapt_Wz, Wz_Wr_En, Wz_Wr_Addr,
         Wz_Wr_Data, Busy, Done, Overrun} !== '0) begin
      failures++; $display("FAIL reset_outputs: some output nonzero, Busy=%b Adapt_Err=%h", Busy, Adapt_Err);
    end
    Reset = 1'b1; Start = 1'b0; Err_In = 11'd0;
    @(negedge clk);
    checks++;
    if (Busy !== 1'b0) begin failures++; $display("FAIL reset_idle_busy: got %b want 0", Busy); end
  endtask

  task automatic test_full_sweep();
    int dc, bc, base, rbase;
    base = wr_addr_qu.size(); rbase = rd_cnt;
    run_sweep(11'h005, dc, bc);
    checks++;
    if (dc !== SWEEP) begin failures++; $display("FAIL full_done_latency: got %0d want %0d", dc, SWEEP); end
    checks++;
    if (bc !== SWEEP) begin failures++; $display("FAIL full_busy_len: got %0d want %0d", bc, SWEEP); end
    checks++;
    if (Adapt_Err !== 11'h005) begin failures++; $display("FAIL full_err: got %h want 005", Adapt_Err); end
    checks++;
    if (rd_cnt - rbase !== NTAPS) begin failures++; $display("FAIL full_reads: got %0d want %0d", rd_cnt - rbase, NTAPS); end
    checks++;
    if (wr_addr_qu.size() - base !== NTAPS) begin
      failures++; $display("FAIL full_writes: got %0d want %0d", wr_addr_qu.size() - base, NTAPS);
    end
    for (int i = 0; i < NTAPS; i++) begin
      if (base + i < wr_addr_qu.size()) begin
        checks++;
        if (wr_addr_qu[base+i] !== 3'(i) || wr_data_qu[base+i] !== exp_w[i] + 11'd1) begin
          failures++; $display("FAIL full_write%0d: got addr %0d data %h want addr %0d data %h",
                               i, wr_addr_qu[base+i], wr_data_qu[base+i], i, exp_w[i] + 11'd1);
        end
        checks++;
        if (wr_sig_qu[base+i] !== sig_mem[i]) begin
          failures++; $display("FAIL full_sig%0d: got %h want %h", i, wr_sig_qu[base+i], sig_mem[i]);
        end
      end
      exp_w[i] = exp_w[i] + 11'd1;
    end
  endtask

  task automatic test_neg_zero();
    int dc, bc, base, rbase;
    base = wr_addr_qu.size(); rbase = rd_cnt;
    run_sweep(11'h400, dc, bc);
    checks++;
    if (dc !== 1) begin failures++; $display("FAIL zero_done_latency: got %0d want 1", dc); end
    checks++;
    if (bc !== 1) begin failures++; $display("FAIL zero_busy_len: got %0d want 1", bc); end
    checks++;
    if ((rd_cnt - rbase) + (wr_addr_qu.size() - base) !== 0) begin
      failures++; $display("FAIL zero_no_access: got %0d reads %0d writes want 0 0", rd_cnt - rbase, wr_addr_qu.size() - base);
    end
    checks++;
    if (Adapt_Err !== 11'h400) begin failures++; $display("FAIL zero_err_latch: got %h want 400", Adapt_Err); end
  endtask

  task automatic test_overrun_mid();
    int cyc, base;
    base = wr_addr_qu.size();
    Start = 1'b1; Err_In = 11'h005;
    @(negedge clk);
    Start = 1'b0;
    repeat (4) @(negedge clk);
    Start = 1'b1; Err_In = 11'h7FF;
    @(negedge clk);
    Start = 1'b0;
    checks++;
    if (Overrun !== 1'b1) begin failures++; $display("FAIL ovr_pulse: got %b want 1", Overrun); end
    @(negedge clk);
    checks++;
    if (Overrun !== 1'b0) begin failures++; $display("FAIL ovr_one_cycle: got %b want 0", Overrun); end
    checks++;
    if (Adapt_Err !== 11'h005) begin failures++; $display("FAIL ovr_err_kept: got %h want 005", Adapt_Err); end
    cyc = 7;
    while (!Done && cyc < 200) begin @(negedge clk); cyc++; end
    checks++;
    if (cyc !== SWEEP) begin failures++; $display("FAIL ovr_done_latency: got %0d want %0d", cyc, SWEEP); end
    repeat (2) @(negedge clk);
    checks++;
    if (wr_addr_qu.size() - base !== NTAPS) begin
      failures++; $display("FAIL ovr_writes: got %0d want %0d", wr_addr_qu.size() - base, NTAPS);
    end
    for (int i = 0; i < NTAPS; i++) exp_w[i] = exp_w[i] + 11'd1;
  endtask

  task automatic test_start_at_done();
    int cyc, base;
    Start = 1'b1; Err_In = 11'h005;
    @(negedge clk);
    Start = 1'b0;
    cyc = 1;
    while (!Done && cyc < 200) begin @(negedge clk); cyc++; end
    Start = 1'b1; Err_In = 11'h006;
    @(negedge clk);
    checks++;
    if (Overrun !== 1'b1 || Busy !== 1'b0) begin
      failures++; $display("FAIL done_start_ignored: got Overrun=%b Busy=%b want 1 0", Overrun, Busy);
    end
    base = wr_addr_qu.size();
    Err_In = 11'h003;
    @(negedge clk);
    Start = 1'b0;
    checks++;
    if (Busy !== 1'b1 || Overrun !== 1'b0 || Adapt_Err !== 11'h003) begin
      failures++; $display("FAIL done_next_accept: got Busy=%b Overrun=%b Err=%h want 1 0 003", Busy, Overrun, Adapt_Err);
    end
    cyc = 1;
    while (!Done && cyc < 200) begin @(negedge clk); cyc++; end
    repeat (2) @(negedge clk);
    checks++;
    if (cyc !== SWEEP || wr_addr_qu.size() - base !== NTAPS) begin
      failures++; $display("FAIL done_next_sweep: got %0d cycles %0d writes want %0d %0d",
                           cyc, wr_addr_qu.size() - base, SWEEP, NTAPS);
    end
    for (int i = 0; i < 2 * NTAPS; i++) exp_w[i % NTAPS] = exp_w[i % NTAPS] + 11'd1;
  endtask

  task automatic test_err_toggle();
    int cyc, bad, rbase, bbase, obase;
    rbase = runs; bbase = bad_run; obase = overlap_cnt; bad = 0;
    Start = 1'b1; Err_In = 11'h005;
    @(negedge clk);
    Start = 1'b0;
    cyc = 1;
    while (!Done && cyc < 200) begin
      Err_In = 11'($urandom);
      if (Adapt_Err !== 11'h005) bad++;
      @(negedge clk);
      cyc++;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL tog_err_stable: got %0d bad cycles want 0", bad); end
    checks++;
    if (runs - rbase !== NTAPS || bad_run - bbase !== 0) begin
      failures++; $display("FAIL tog_en_runs: got %0d runs %0d bad want %0d 0", runs - rbase, bad_run - bbase, NTAPS);
    end
    checks++;
    if (overlap_cnt - obase !== 0) begin failures++; $display("FAIL tog_en_overlap: got %0d want 0", overlap_cnt - obase); end
    for (int i = 0; i < NTAPS; i++) exp_w[i] = exp_w[i] + 11'd1;
  endtask

  task automatic test_reset_mid_exec();
    int dc, bc, base;
    base = wr_addr_qu.size();
    Start = 1'b1; Err_In = 11'h005;
    @(negedge clk);
    Start = 1'b0;
    repeat (13) @(negedge clk);
    checks++;
    if (Adapt_En !== 1'b1 || Tap_Addr !== 3'd3) begin
      failures++; $display("FAIL rst_mid_pos: got En=%b Tap=%0d want 1 3", Adapt_En, Tap_Addr);
    end
    Reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({Tap_Addr, Rd_En, Adapt_En, Adapt_Sig, Adapt_Err, Adapt_Wz, Wz_Wr_En, Wz_Wr_Addr,
         Wz_Wr_Data, Busy, Done, Overrun} !== '0) begin
      failures++; $display("FAIL rst_mid_outputs: got Busy=%b En=%b Tap=%0d want all zero", Busy, Adapt_En, Tap_Addr);
    end
    @(negedge clk);
    Reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (wr_addr_qu.size() - base !== 3) begin
      failures++; $display("FAIL rst_mid_dropped: got %0d writes want 3", wr_addr_qu.size() - base);
    end
    for (int i = 0; i < 3; i++) exp_w[i] = exp_w[i] + 11'd1;
    base = wr_addr_qu.size();
    run_sweep(11'h005, dc, bc);
    checks++;
    if (dc !== SWEEP || wr_addr_qu.size() - base !== NTAPS) begin
      failures++; $display("FAIL rst_resweep: got %0d cycles %0d writes want %0d %0d", dc, wr_addr_qu.size() - base, SWEEP, NTAPS);
    end
    for (int i = 0; i < NTAPS; i++) begin
      if (base + i < wr_addr_qu.size()) begin
        checks++;
        if (wr_addr_qu[base+i] !== 3'(i) || wr_data_qu[base+i] !== exp_w[i] + 11'd1) begin
          failures++; $display("FAIL rst_write%0d: got addr %0d data %h want addr %0d data %h",
                               i, wr_addr_qu[base+i], wr_data_qu[base+i], i, exp_w[i] + 11'd1);
        end
      end
      exp_w[i] = exp_w[i] + 11'd1;
    end
  endtask

  initial begin
    exp_w = '{11'h010, 11'h020, 11'h030, 11'h040};
    @(negedge clk);
    test_reset();
    test_full_sweep();
    test_neg_zero();
    test_overrun_mid();
    test_start_at_done();
    test_err_toggle();
    test_reset_mid_exec();
    checks++;
    if (overlap_cnt !== 0 || range_cnt !== 0) begin
      failures++; $display("FAIL global_protocol: got overlap=%0d range=%0d want 0 0", overlap_cnt, range_cnt);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/anc_adapt_sched.md
Name: anc_adapt_sched

Overview:
- Sequencer that time-shares one LMS weight-update datapath (multiplier + signed adder, 11-bit sign-magnitude) across all taps of the adaptive FIR.
- On each audio-sample strobe it latches the error sample, then walks taps 0..NTAPS-1:
  - reads the reference sample and the current weight,
  - drives the datapath for a fixed latency,
  - writes the updated weight back to weight RAM.
- Sits between the sample/weight memories and the adaptation datapath; reports Busy/Done to the top-level ANC controller.

Parameters:
- NTAPS, 16, number of filter taps swept per sample (>=2).
- AW, 4, tap address width; 2**AW >= NTAPS.
- DP_LAT, 2, cycles Adapt_En stays high per tap before WzOut is valid (>=1).

Ports:
- Clk_100M  in  1  system clock; all logic on rising edge.
- Reset  in  1  synchronous, active-low reset.
- Start  in  1  one-cycle sample strobe; begins a sweep.
- Err_In  in  11  error sample, sign-magnitude ([10] sign, [9:0] magnitude).
- Tap_Addr  out  AW  read address to sample delay line and weight RAM.
- Rd_En  out  1  read enable for both memories; data returned next cycle.
- Sig_Data  in  11  delay-line sample at Tap_Addr (1-cycle latency).
- Wz_Data  in  11  weight at Tap_Addr (1-cycle latency).
- Adapt_En  out  1  datapath enable (FilterEN).
- Adapt_Sig  out  11  registered sample to datapath.
- Adapt_Err  out  11  registered error to datapath.
- Adapt_Wz  out  11  registered old weight to datapath.
- Adapt_WzOut  in  11  updated weight from datapath.
- Wz_Wr_En  out  1  weight RAM write strobe.
- Wz_Wr_Addr  out  AW  weight write address.
- Wz_Wr_Data  out  11  weight write data.
- Busy  out  1  high from Start acceptance until the Done cycle inclusive.
- Done  out  1  one-cycle pulse at sweep end.
- Overrun  out  1  one-cycle pulse when Start arrives while not IDLE.

Behaviour:
- Reset low at any clock edge:
  - State goes to IDLE.
  - Every output, the tap counter and the latched error go to 0.
  - Any in-flight write is dropped (no Wz_Wr_En).
  - Reset has priority over Start.
- FSM states: IDLE, READ, EXEC, WRITE, FIN.
- IDLE:
  - Start=1 latches Err_In into Adapt_Err and sets Tap_Addr=0.
  - If Err_In[9:0]==0 (zero error, either sign), go to FIN: no reads, no writes.
  - Otherwise go to READ.
- READ (1 cycle): Rd_En=1 at Tap_Addr.
- EXEC (DP_LAT cycles):
  - On the first EXEC cycle, capture Sig_Data into Adapt_Sig and Wz_Data into Adapt_Wz.
  - Adapt_En=1 for all DP_LAT cycles; an internal latency counter counts them.
- WRITE (1 cycle):
  - Adapt_En=0, Wz_Wr_En=1, Wz_Wr_Addr=Tap_Addr, Wz_Wr_Data=Adapt_WzOut sampled at the end of the last EXEC cycle.
  - If Tap_Addr==NTAPS-1, go to FIN; else Tap_Addr+1 and go to READ.
- FIN (1 cycle): Done=1, Busy=1, Tap_Addr returns to 0; next state IDLE.
- Timing:
  - Per tap: DP_LAT+2 cycles.
  - Start to Done: NTAPS*(DP_LAT+2)+1 cycles for a full sweep; 1 cycle for a zero-error skip.
- Start outside IDLE (including FIN):
  - Ignored; Overrun=1 for that cycle.
  - Adapt_Err is not modified; the sweep continues unaffected.
- Adapt_Err holds constant for the whole sweep, even if Err_In changes.
- No arithmetic in this block; the 11-bit sign-magnitude format is passed through unmodified. Saturation and the mu scaling belong to the datapath.
- Tap_Addr never exceeds NTAPS-1, even when 2**AW > NTAPS.
- Rd_En and Wz_Wr_En are never high in the same cycle.

Test Plan:
- Reset low for 2 cycles during EXEC of tap 3 -> next cycle all outputs 0, state IDLE, no write to addr 3; Start after release runs a clean sweep from tap 0.
- NTAPS=4, DP_LAT=2, Start with Err_In=11'h005, Adapt_WzOut model = Adapt_Wz+1:
  - Done exactly 17 cycles after Start.
  - Exactly 4 writes, to addr 0,1,2,3 in order, each carrying old weight+1.
  - Busy high for 17 cycles.
- Start with Err_In=11'h400 (negative zero) -> Done 1 cycle later, Rd_En and Wz_Wr_En never asserted.
- Start repeated 5 cycles into a sweep with Err_In=11'h7FF -> Overrun pulses 1 cycle, Adapt_Err keeps 11'h005, sweep completes with 4 writes.
- Start asserted in the same cycle as Done -> Overrun=1, no new sweep; Start one cycle later -> accepted normally.
- Err_In toggled every cycle during a sweep -> Adapt_Err stable; Adapt_En high exactly DP_LAT consecutive cycles per tap, low during READ/WRITE.
